// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and the
// LEGv8 instruction field constants used by fetch and decode.
package instruction_fetch_unit_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } ifu_state_e;

    localparam int INSTR_W = 32;
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 21;
    localparam int OPC_W   = OPC_HI - OPC_LO + 1;
    localparam int PC_INC  = 4;

endpackage

// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch front end: walks the PC, fetches words over req/ack and presents
// one registered instruction (word, opcode, PC) at a time to decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                CLOCK,
    input  logic                RESET,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr_out,
    output logic [OPC_W-1:0]    opcode_out,
    output logic [PC_WIDTH-1:0] pc_out,
    output ifu_state_e          state_dbg
);

    // Handshake: a fetch is accepted on a rising edge where imem_req=1 and
    // imem_ack=1; imem_addr is held from the rise of imem_req until that edge.
    // Decode consumes the presented instruction on an edge with instr_valid=1
    // and stall=0.

    ifu_state_e            state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  redir_pending_q, redir_pending_d;
    logic [PC_WIDTH-1:0]   redir_pc_q, redir_pc_d;
    logic                  req_q, req_d;
    logic                  valid_q, valid_d;
    logic [INSTR_W-1:0]    instr_q, instr_d;
    logic [OPC_W-1:0]      opcode_q, opcode_d;
    logic [PC_WIDTH-1:0]   pc_out_q, pc_out_d;

    logic [PC_WIDTH-1:0]   target_aligned;
    logic                  ack_taken;
    logic                  redirect_hit;

    assign target_aligned = branch_target & ~PC_WIDTH'(3);
    // req_q is low only in the first cycle after reset; an ack then is stale.
    assign ack_taken      = (state_q == FETCH) && req_q && imem_ack;
    assign redirect_hit   = redir_pending_q || branch_taken;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q         <= FETCH;
            pc_q            <= RESET_PC;
            redir_pending_q <= 1'b0;
            redir_pc_q      <= '0;
            req_q           <= 1'b0;
            valid_q         <= 1'b0;
            instr_q         <= '0;
            opcode_q        <= '0;
            pc_out_q        <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            redir_pending_q <= redir_pending_d;
            redir_pc_q      <= redir_pc_d;
            req_q           <= req_d;
            valid_q         <= valid_d;
            instr_q         <= instr_d;
            opcode_q        <= opcode_d;
            pc_out_q        <= pc_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (ack_taken && !redirect_hit) state_d = ISSUE;
            ISSUE: if (branch_taken || !stall)     state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_d            = pc_q;
        redir_pending_d = redir_pending_q;
        redir_pc_d      = redir_pc_q;
        valid_d         = valid_q;
        instr_d         = instr_q;
        opcode_d        = opcode_q;
        pc_out_d        = pc_out_q;
        case (state_q)
            FETCH: begin
                if (ack_taken) begin
                    if (redirect_hit) begin
                        // Word belongs to the wrong path; drop it and refetch.
                        pc_d            = branch_taken ? target_aligned : redir_pc_q;
                        redir_pending_d = 1'b0;
                    end else begin
                        instr_d  = imem_rdata;
                        opcode_d = imem_rdata[OPC_HI:OPC_LO];
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + PC_WIDTH'(PC_INC);
                    end
                end else if (branch_taken) begin
                    redir_pending_d = 1'b1;
                    redir_pc_d      = target_aligned;
                end
            end
            ISSUE: begin
                if (branch_taken) begin
                    valid_d = 1'b0;
                    pc_d    = target_aligned;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        req_d = (state_d == FETCH);
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr_out   = instr_q;
    assign opcode_out  = opcode_q;
    assign pc_out      = pc_out_q;
    assign state_dbg   = state_q;

endmodule
